// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pkg
// Brief    : Shared types for the GraphicsCard op scheduler and its FIFO.
// Revision : 1.0
// ============================================================================
package gfx_pkg;

    localparam int C_X_W = 9;
    localparam int C_Y_W = 8;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_BLIT = 1'b1
    } gfx_op_t;

    typedef struct packed {
        gfx_op_t            op;
        logic               fill_value;
        logic [C_X_W-1:0]   x1;
        logic [C_Y_W-1:0]   y1;
        logic [C_X_W-1:0]   x2;
        logic [C_Y_W-1:0]   y2;
        logic [C_X_W-1:0]   w;
        logic [C_Y_W-1:0]   h;
    } gfx_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/gfx_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gfx_cmd_fifo
// Brief    : Synchronous command FIFO of gfx_cmd_t. Flush path present only
//            when GFX_SCHED_FLUSH_EN is defined.
// Revision : 1.0
// ============================================================================
module gfx_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  gfx_cmd_t               push_cmd,
    input  logic                   pop,
    input  logic                   flush,
    output gfx_cmd_t               head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

    gfx_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            w_do_push;
    logic            w_do_pop;

    always_comb begin
        w_do_push = push && (count_q != C_DEPTH);
        w_do_pop  = pop && (count_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - 1'b1;
        end
`ifdef GFX_SCHED_FLUSH_EN
        // Flush wins over a same-cycle push; the popped head is already in flight.
        if (flush) begin
            w_do_push = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
`endif
    end

`ifndef GFX_SCHED_FLUSH_EN
    logic w_unused_flush;
    assign w_unused_flush = flush;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/gfx_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gfx_op_scheduler
// Brief    : Queues host fill/blit requests and issues them one at a time to
//            the GraphicsCard. Optional queue flush: GFX_SCHED_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module gfx_op_scheduler
    import gfx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_fill,
    input  logic                   req_blit,
    input  logic                   req_fill_value,
    input  logic [C_X_W-1:0]       req_X1,
    input  logic [C_X_W-1:0]       req_X2,
    input  logic [C_Y_W-1:0]       req_Y1,
    input  logic [C_Y_W-1:0]       req_Y2,
    input  logic [C_X_W-1:0]       req_width,
    input  logic [C_Y_W-1:0]       req_height,
    input  logic                   flush,
    input  logic                   clear_status,
    output logic                   start_fill,
    output logic                   start_blit,
    output logic                   fill_value,
    output logic [C_X_W-1:0]       X1,
    output logic [C_Y_W-1:0]       Y1,
    output logic [C_X_W-1:0]       X2,
    output logic [C_Y_W-1:0]       Y2,
    output logic [C_X_W-1:0]       op_x_width,
    output logic [C_Y_W-1:0]       op_y_height,
    input  logic                   busy,
    input  logic                   error,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   queue_full,
    output logic                   idle,
    output logic                   overflow,
    output logic                   cmd_err,
    output logic                   card_err
);

    localparam int              TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   C_ACK_LAST = TW'(ACK_TIMEOUT - 1);

    sched_state_t               state_q, state_d;
    logic [TW-1:0]              ack_cnt_q, ack_cnt_d;
    gfx_cmd_t                   cmd_q, cmd_d;
    logic                       start_fill_q, start_fill_d;
    logic                       start_blit_q, start_blit_d;
    logic                       overflow_q, overflow_d;
    logic                       cmd_err_q, cmd_err_d;
    logic                       card_err_q, card_err_d;

    logic                       w_any_req;
    logic                       w_both_req;
    logic                       w_push;
    logic                       w_pop;
    gfx_cmd_t                   w_push_cmd;
    gfx_cmd_t                   w_head;
    logic [$clog2(DEPTH):0]     w_count;
    logic                       w_full;
    logic                       w_unused_op;

    assign w_any_req  = req_fill || req_blit;
    assign w_both_req = req_fill && req_blit;
    assign w_push     = (req_fill ^ req_blit) && !w_full;

    always_comb begin
        w_push_cmd            = '0;
        w_push_cmd.op         = req_blit ? OP_BLIT : OP_FILL;
        w_push_cmd.fill_value = req_fill_value;
        w_push_cmd.x1         = req_X1;
        w_push_cmd.y1         = req_Y1;
        w_push_cmd.x2         = req_X2;
        w_push_cmd.y2         = req_Y2;
        w_push_cmd.w          = req_width;
        w_push_cmd.h          = req_height;
    end

    gfx_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_cmd (w_push_cmd),
        .pop      (w_pop),
        .flush    (flush),
        .head     (w_head),
        .count    (w_count),
        .full     (w_full)
    );

    // Start pulses are decided at pop time so they are registered and
    // coincide with the first cycle the operand registers are valid.
    always_comb begin
        state_d      = state_q;
        ack_cnt_d    = ack_cnt_q;
        cmd_d        = cmd_q;
        start_fill_d = 1'b0;
        start_blit_d = 1'b0;
        w_pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((w_count != '0) && !busy) begin
                    w_pop        = 1'b1;
                    cmd_d        = w_head;
                    start_fill_d = (w_head.op == OP_FILL);
                    start_blit_d = (w_head.op == OP_BLIT);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ack_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == C_ACK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = (overflow_q && !clear_status) || (w_any_req && w_full);
        cmd_err_d  = (cmd_err_q && !clear_status) || w_both_req;
        card_err_d = (card_err_q && !clear_status) ||
                     (error && ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ack_cnt_q    <= '0;
            cmd_q        <= '0;
            start_fill_q <= 1'b0;
            start_blit_q <= 1'b0;
            overflow_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            card_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            cmd_q        <= cmd_d;
            start_fill_q <= start_fill_d;
            start_blit_q <= start_blit_d;
            overflow_q   <= overflow_d;
            cmd_err_q    <= cmd_err_d;
            card_err_q   <= card_err_d;
        end
    end

    assign w_unused_op = cmd_q.op;

    assign start_fill  = start_fill_q;
    assign start_blit  = start_blit_q;
    assign fill_value  = cmd_q.fill_value;
    assign X1          = cmd_q.x1;
    assign Y1          = cmd_q.y1;
    assign X2          = cmd_q.x2;
    assign Y2          = cmd_q.y2;
    assign op_x_width  = cmd_q.w;
    assign op_y_height = cmd_q.h;
    assign queue_count = w_count;
    assign queue_full  = w_full;
    assign idle        = (w_count == '0) && (state_q == ST_IDLE) && !busy;
    assign overflow    = overflow_q;
    assign cmd_err     = cmd_err_q;
    assign card_err    = card_err_q;

endmodule
`default_nettype wire

// File: doc/gfx_op_scheduler.md
# gfx_op_scheduler

Command scheduler between the EPP host interface and the GraphicsCard datapath. Buffers fill/blit requests strobed by the host in a small FIFO and issues them one at a time to the GraphicsCard. Issues only when the card is idle, holding operands stable for the whole operation. Also tracks completion, card errors and host protocol errors, so the host can post several operations back-to-back without polling `busy`.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `ACK_TIMEOUT`, 4: cycles to wait for `busy` to rise after a start pulse before treating the op as complete.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `req_fill`, `req_blit`  in  1 each  one-cycle enqueue strobes from EPP.
- `req_fill_value`  in  1  fill colour operand.
- `req_X1`, `req_X2`  in  9 each; `req_Y1`, `req_Y2`  in  8 each  corner operands.
- `req_width`  in  9; `req_height`  in  8  op extent.
- `flush`  in  1  drop all queued (not in-flight) commands; see Configuration.
- `clear_status`  in  1  clears sticky flags.
- `start_fill`, `start_blit`  out  1 each  one-cycle start pulses to GraphicsCard.
- `fill_value`, `X1`, `Y1`, `X2`, `Y2`, `op_x_width`, `op_y_height`  out  operand registers, same widths as `req_*`.
- `busy`  in  1  GraphicsCard busy.
- `error`  in  1  GraphicsCard error.
- `queue_count`  out  $clog2(DEPTH)+1  entries queued.
- `queue_full`  out  1  `queue_count == DEPTH`.
- `idle`  out  1  queue empty, FSM in IDLE, `busy` low.
- `overflow`, `cmd_err`, `card_err`  out  1 each  sticky status.

## Operation
- Enqueue: a cycle with exactly one of `req_fill`/`req_blit` high pushes {op, operands}.
- Dropped requests:
  - Strobe while `queue_full`: dropped, `overflow` set. This applies even if a pop occurs the same cycle.
  - Both strobes high in one cycle: nothing is pushed, `cmd_err` set.
- FSM states:
  - IDLE: if count>0 and `busy` low, pop the head into the operand registers, then go to ISSUE.
  - ISSUE: pulse `start_fill` or `start_blit` for one cycle, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if `busy`, go to WAIT_DONE. Otherwise, once the counter reaches ACK_TIMEOUT-1, go to IDLE (degenerate op finished instantly).
  - WAIT_DONE: when `busy` falls, go to IDLE.
- Operand outputs change only on pop; they hold through WAIT_DONE and after it.
- `error` high in WAIT_ACK or WAIT_DONE sets `card_err`. The scheduler keeps running.
- `clear_status`: clears `overflow`, `cmd_err` and `card_err`. A set event in the same cycle wins.
- Push and pop in the same cycle (not full): count unchanged, FIFO order preserved.
- Pointer wrap: modulo DEPTH; count saturates logically at DEPTH because full drops pushes.
- Reset (any time, including mid-op):
  - FIFO emptied and FSM forced to IDLE.
  - Start pulses 0, operand registers 0, sticky flags 0.
  - `queue_full` 0, `queue_count` 0.
  - `idle` follows `busy`.
  - The in-flight card op is not aborted; the next issue waits for `busy` low.

## Timing
- Latency: a strobe in cycle t (empty, IDLE, `busy` low) gives count=1 at t+1, pop at t+1, operand registers valid at t+2, start pulse at t+2.
- Start pulse is exactly one cycle; operands are valid in that same cycle.
- Minimum spacing between start pulses is 3 cycles when the op is instant and `busy` never rises, with ACK_TIMEOUT=1. With the default ACK_TIMEOUT=4 it is 6 cycles.
- All outputs registered, except `idle` and `queue_full`, which decode registered state (`idle` also uses `busy`).

## Configuration
- `GFX_SCHED_FLUSH_EN` defined:
  - `flush` high in a cycle empties the FIFO.
  - Count is 0 next cycle; a simultaneous push is dropped (no flag).
  - The in-flight op continues.
- Undefined: `flush` is ignored; FIFO logic has no flush path.

## Structure
- Package `gfx_pkg`:
  - `gfx_op_t` enum {OP_FILL, OP_BLIT}.
  - `gfx_cmd_t` struct {op, fill_value, x1[8:0], y1[7:0], x2[8:0], y2[7:0], w[8:0], h[7:0]} (53 bits).
  - Scheduler state enum; coordinate width constants.
- Sub-module `gfx_cmd_fifo`:
  - Synchronous FIFO of `gfx_cmd_t`.
  - Ports: push, pop, flush, head, count, full.

## Test plan
- Single fill (X1=5, Y1=3, w=10, h=2, value=1) with `busy` high for 20 cycles after start: `start_fill` pulses once at t+2, operands stable until the next pop, `idle` returns after `busy` falls.
- Four blits strobed on consecutive cycles while `busy` held high: count reaches 4, `queue_full`=1, no start pulses. Release `busy`: four `start_blit` pulses in FIFO order.
- Fifth strobe with queue full: `overflow`=1, count stays 4. `clear_status`: `overflow`=0.
- `req_fill` and `req_blit` in the same cycle: count unchanged, `cmd_err`=1.
- `busy` never rises after a start, ACK_TIMEOUT=4: FSM is back in IDLE 4 cycles after WAIT_ACK entry, and the next queued op issues.
- With `GFX_SCHED_FLUSH_EN`, 3 queued plus one in flight, pulse `flush`: count=0, the in-flight op completes, no further starts. Without the macro: all 3 issue.
